// File: rtl/uart_pkg.sv
// Shared UART constants, baud-controller state type and rate table.
package uart_pkg;

    localparam logic [16:0] BAUD_1200   = 17'd1200;
    localparam logic [16:0] BAUD_2400   = 17'd2400;
    localparam logic [16:0] BAUD_4800   = 17'd4800;
    localparam logic [16:0] BAUD_9600   = 17'd9600;
    localparam logic [16:0] BAUD_14400  = 17'd14400;
    localparam logic [16:0] BAUD_19200  = 17'd19200;
    localparam logic [16:0] BAUD_38400  = 17'd38400;
    localparam logic [16:0] BAUD_57600  = 17'd57600;
    localparam logic [16:0] BAUD_115200 = 17'd115200;

    localparam logic [3:0] TICK_FULL = 4'hF;

    typedef enum logic [2:0] {
        RESET_SETTLE,
        IDLE,
        CHECK,
        DRAIN,
        APPLY,
        SETTLE
    } baud_ctrl_state_t;

    function automatic logic baud_is_supported(logic [16:0] rate);
        logic ok;
        ok = 1'b0;
        case (rate)
            BAUD_1200, BAUD_2400, BAUD_4800,
            BAUD_9600, BAUD_14400, BAUD_19200,
            BAUD_38400, BAUD_57600, BAUD_115200: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/uart_tick_strobe.sv
// Rising-into-full-phase detector on the baud generator tick phase.
module uart_tick_strobe
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic [3:0] tick_i,
    output logic       strobe_o
);

    // Plain history flop: previous cycle's tick, reset-independent.
    logic [3:0] tick_q;

    always_ff @(posedge clk) begin
        tick_q <= tick_i;
    end

    assign strobe_o = (tick_i == TICK_FULL) && (tick_q != TICK_FULL);

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud-rate change controller: validate, quiesce link, apply, settle.
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEFAULT_BAUD  = 9600,
    parameter int unsigned SETTLE_BITS   = 2,
    parameter int unsigned DRAIN_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [16:0] cfg_baud,
    output logic        cfg_ack,
    output logic        cfg_err,
    input  logic        link_busy,
    output logic        quiesce,
    input  logic [3:0]  tick,
    output logic [16:0] baud_rate,
    output logic        baud_valid
);

    localparam int unsigned DW =
        (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_BITS - 1);
    localparam logic [16:0]   DEF_RATE    = 17'(DEFAULT_BAUD);

    baud_ctrl_state_t state_q, state_d;
    logic [16:0]      req_q, req_d;
    logic [16:0]      rate_q, rate_d;
    logic             valid_q, valid_d;
    logic             quiesce_q, quiesce_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [3:0]       bits_q, bits_d;
    logic             strobe;

    uart_tick_strobe u_strobe (
        .clk      (clk),
        .tick_i   (tick),
        .strobe_o (strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_SETTLE;
            req_q     <= DEF_RATE;
            rate_q    <= DEF_RATE;
            valid_q   <= 1'b0;
            quiesce_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            drain_q   <= '0;
            bits_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rate_q    <= rate_d;
            valid_q   <= valid_d;
            quiesce_q <= quiesce_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            drain_q   <= drain_d;
            bits_q    <= bits_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rate_d    = rate_q;
        valid_d   = valid_q;
        quiesce_d = quiesce_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        drain_d   = drain_q;
        bits_d    = bits_q;
        unique case (state_q)
            RESET_SETTLE: begin
                if (strobe) begin
                    if (bits_q == SETTLE_LAST) begin
                        valid_d = 1'b1;
                        bits_d  = '0;
                        state_d = IDLE;
                    end else begin
                        bits_d = bits_q + 4'd1;
                    end
                end
            end
            IDLE: begin
                // The ack cycle never starts a new request.
                if (cfg_req && !ack_q) begin
                    req_d   = cfg_baud;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!baud_is_supported(req_q)) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (req_q == rate_q) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    quiesce_d = 1'b1;
                    drain_d   = '0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (!link_busy) begin
                    state_d = APPLY;
                end else if (drain_q == DRAIN_LAST) begin
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    quiesce_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            APPLY: begin
                rate_d  = req_q;
                valid_d = 1'b0;
                bits_d  = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (strobe) begin
                    if (bits_q == SETTLE_LAST) begin
                        valid_d   = 1'b1;
                        quiesce_d = 1'b0;
                        ack_d     = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bits_d = bits_q + 4'd1;
                    end
                end
            end
            default: state_d = RESET_SETTLE;
        endcase
    end

    assign cfg_ack    = ack_q;
    assign cfg_err    = err_q;
    assign quiesce    = quiesce_q;
    assign baud_rate  = rate_q;
    assign baud_valid = valid_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl with a per-cycle reference model.
module tb_uart_baud_ctrl;

    localparam int T = 50;
    localparam int SB = 2;

    localparam int M_BOOT   = 0;
    localparam int M_IDLE   = 1;
    localparam int M_CHK    = 2;
    localparam int M_DRAIN  = 3;
    localparam int M_APPLY  = 4;
    localparam int M_SETTLE = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0;
    logic [16:0] cfg_baud = '0;
    logic        link_busy = 1'b0;
    logic [3:0]  tick = 4'd0;
    logic        cfg_ack;
    logic        cfg_err;
    logic        quiesce;
    logic [16:0] baud_rate;
    logic        baud_valid;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: outputs expected in the current cycle.
    int       m_rate = 9600;
    bit       m_valid = 0;
    bit       m_q = 0;
    bit       m_ack = 0;
    bit       m_err = 0;
    logic [3:0] m_prev = 4'd0;
    int       ph = M_BOOT;
    int       left = SB;
    int       j_rate = 0;

    uart_baud_ctrl #(
        .DEFAULT_BAUD  (9600),
        .SETTLE_BITS   (SB),
        .DRAIN_TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_req    (cfg_req),
        .cfg_baud   (cfg_baud),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .link_busy  (link_busy),
        .quiesce    (quiesce),
        .tick       (tick),
        .baud_rate  (baud_rate),
        .baud_valid (baud_valid)
    );

    always #5 clk = ~clk;

    function automatic bit supported(int r);
        int tbl [9];
        bit hit;
        tbl = '{1200, 2400, 4800, 9600, 14400,
                19200, 38400, 57600, 115200};
        hit = 0;
        foreach (tbl[i]) if (tbl[i] == r) hit = 1;
        return hit;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Advance model by one clock edge using this cycle's inputs.
    task automatic model_step();
        bit stb;
        bit was_ack;
        stb = (tick == 4'hF) && (m_prev != 4'hF);
        m_prev = tick;
        was_ack = m_ack;
        m_ack = 0;
        m_err = 0;
        if (rst) begin
            m_rate = 9600;
            m_valid = 0;
            m_q = 0;
            ph = M_BOOT;
            left = SB;
        end else begin
            case (ph)
                M_BOOT: if (stb) begin
                    left--;
                    if (left == 0) begin
                        m_valid = 1;
                        ph = M_IDLE;
                    end
                end
                M_IDLE: if (cfg_req && !was_ack) begin
                    j_rate = int'(cfg_baud);
                    ph = M_CHK;
                end
                M_CHK: begin
                    if (!supported(j_rate)) begin
                        m_ack = 1;
                        m_err = 1;
                        ph = M_IDLE;
                    end else if (j_rate == m_rate) begin
                        m_ack = 1;
                        ph = M_IDLE;
                    end else begin
                        m_q = 1;
                        left = T;
                        ph = M_DRAIN;
                    end
                end
                M_DRAIN: begin
                    if (!link_busy) begin
                        ph = M_APPLY;
                    end else begin
                        left--;
                        if (left == 0) begin
                            m_ack = 1;
                            m_err = 1;
                            m_q = 0;
                            ph = M_IDLE;
                        end
                    end
                end
                M_APPLY: begin
                    m_rate = j_rate;
                    m_valid = 0;
                    left = SB;
                    ph = M_SETTLE;
                end
                M_SETTLE: if (stb) begin
                    left--;
                    if (left == 0) begin
                        m_valid = 1;
                        m_q = 0;
                        m_ack = 1;
                        ph = M_IDLE;
                    end
                end
                default: ph = M_BOOT;
            endcase
        end
    endtask

    // One clock: update model at the edge, compare at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("baud_rate", int'(baud_rate), m_rate);
        chk("baud_valid", int'(baud_valid), int'(m_valid));
        chk("quiesce", int'(quiesce), int'(m_q));
        chk("cfg_ack", int'(cfg_ack), int'(m_ack));
        chk("cfg_err", int'(cfg_err), int'(m_err));
        tick = tick + 4'd1;
    endtask

    task automatic req(input int rate, input int busy_until,
                       input int pk, output int lat,
                       output int rb, output int ra,
                       output int q2, output int err);
        int k;
        k = 0;
        lat = -1;
        rb = 0;
        ra = 0;
        q2 = 0;
        err = 0;
        cfg_req = 1'b1;
        cfg_baud = 17'(rate);
        while (k < 600 && lat < 0) begin
            link_busy = (k < busy_until);
            cyc();
            k++;
            if (k == 2) q2 = int'(quiesce);
            if (k == pk - 1) rb = int'(baud_rate);
            if (k == pk) ra = int'(baud_rate);
            if (cfg_ack) begin
                lat = k;
                err = int'(cfg_err);
            end
        end
        cfg_req = 1'b0;
        link_busy = 1'b0;
        chk("ack_seen", int'(lat >= 0), 1);
    endtask

    task automatic wait_valid(string name);
        int k;
        k = 0;
        while (k < 200 && !baud_valid) begin
            cyc();
            k++;
        end
        chk(name, int'(baud_valid), 1);
    endtask

    initial begin
        int lat, rb, ra, q2, e;

        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_rate", int'(baud_rate), 9600);
        chk("rst_valid", int'(baud_valid), 0);
        chk("rst_ack", int'(cfg_ack), 0);
        rst = 1'b0;
        wait_valid("boot_valid");

        req(10000, 0, 4, lat, rb, ra, q2, e);
        chk("inv_lat", lat, 2);
        chk("inv_err", e, 1);
        chk("inv_q", q2, 0);
        chk("inv_rate", int'(baud_rate), 9600);
        repeat (3) cyc();

        req(9600, 0, 4, lat, rb, ra, q2, e);
        chk("same_lat", lat, 2);
        chk("same_err", e, 0);
        chk("same_valid", int'(baud_valid), 1);
        repeat (3) cyc();

        req(115200, 0, 4, lat, rb, ra, q2, e);
        chk("chg_q2", q2, 1);
        chk("chg_rate3", rb, 9600);
        chk("chg_rate4", ra, 115200);
        chk("chg_err", e, 0);
        chk("chg_valid", int'(baud_valid), 1);
        repeat (2) cyc();
        chk("chg_qoff", int'(quiesce), 0);

        req(38400, 1000, 4, lat, rb, ra, q2, e);
        chk("to_lat", lat, T + 2);
        chk("to_err", e, 1);
        chk("to_rate", int'(baud_rate), 115200);
        repeat (3) cyc();

        req(38400, 20, 22, lat, rb, ra, q2, e);
        chk("dr_rate21", rb, 115200);
        chk("dr_rate22", ra, 38400);
        chk("dr_err", e, 0);
        repeat (3) cyc();

        cfg_req = 1'b1;
        cfg_baud = 17'd57600;
        repeat (6) cyc();
        chk("mid_q", int'(quiesce), 1);
        chk("mid_rate", int'(baud_rate), 57600);
        chk("mid_valid", int'(baud_valid), 0);
        cfg_req = 1'b0;
        rst = 1'b1;
        cyc();
        chk("rr_rate", int'(baud_rate), 9600);
        chk("rr_valid", int'(baud_valid), 0);
        chk("rr_ack", int'(cfg_ack), 0);
        rst = 1'b0;
        wait_valid("rr_valid_back");
        repeat (5) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
